clock: RTL and testbench

- Real-time hours/minutes/seconds timekeeper driven by one system clock.
- A prescaler generates a 1 Hz tick that advances sec, then min, then hr.
- Two push-button inputs (set_min, set_hr) manually advance minutes and hours.
- A mode button (set_TMOD) toggles the hr output between 24-hour and 12-hour presentation. The block sits between debounced user buttons and the display driver.

---
 rtl/clock_pkg.sv | 19 +
 rtl/clock_btn_edge.sv | 18 +
 rtl/clock.sv | 78 +++++++
 tb/tb_clock.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// Shared constants, mode type and hour-display decode for the clock timekeeper.
package clock_pkg;

  localparam logic [5:0] SEC_MAX   = 6'd59;
  localparam logic [5:0] MIN_MAX   = 6'd59;
  localparam logic [4:0] HR24_MAX  = 5'd23;
  localparam logic [4:0] HR12_NOON = 5'd12;

  typedef enum logic {MODE_24H, MODE_12H} tmode_e;

  // 12h presentation folds 0..23 onto 1..12, with midnight/noon shown as 12.
  function automatic logic [4:0] hr_display(input logic [4:0] h24, input tmode_e mode);
    logic [4:0] h12;
    h12 = (h24 >= HR12_NOON) ? h24 - HR12_NOON : h24;
    if (mode == MODE_24H) return h24;
    return (h12 == 5'd0) ? HR12_NOON : h12;
  endfunction

endpackage

// File: rtl/clock_btn_edge.sv
// Registered rising-edge detector: one press pulse per 0->1 transition of a button.
module clock_btn_edge (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic press
);

  logic prev_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) prev_q <= 1'b0;
    else      prev_q <= in;
  end

  assign press = in & ~prev_q;

endmodule

// File: rtl/clock.sv
// Hours/minutes/seconds timekeeper with 1 Hz prescaler, set buttons and 12h/24h display mode.
module clock
  import clock_pkg::*;
#(
  parameter int unsigned TICKS_PER_SEC = 50_000_000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       set_TMOD,
  input  logic       set_min,
  input  logic       set_hr,
  output logic [5:0] sec,
  output logic [5:0] min,
  output logic [4:0] hr
);

  localparam int unsigned CNT_W = (TICKS_PER_SEC > 1) ? $clog2(TICKS_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TICKS_PER_SEC - 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [5:0]       sec_q, sec_d;
  logic [5:0]       min_q, min_d;
  logic [4:0]       hour_q, hour_d;
  tmode_e           mode_q, mode_d;

  logic press_tmod, press_min, press_hr;
  logic tick, carry_min, carry_hr;

  clock_btn_edge u_edge_tmod (.clk(clk), .rst(rst), .in(set_TMOD), .press(press_tmod));
  clock_btn_edge u_edge_min  (.clk(clk), .rst(rst), .in(set_min),  .press(press_min));
  clock_btn_edge u_edge_hr   (.clk(clk), .rst(rst), .in(set_hr),   .press(press_hr));

  assign tick      = (cnt_q == CNT_LAST);
  assign carry_min = tick && (sec_q == SEC_MAX);
  // A minute press owns the minute field this cycle, so no carry propagates past it.
  assign carry_hr  = carry_min && (min_q == MIN_MAX) && !press_min;

  always_comb begin
    cnt_d  = tick ? '0 : cnt_q + CNT_W'(1);
    sec_d  = sec_q;
    min_d  = min_q;
    hour_d = hour_q;
    mode_d = mode_q;

    if (tick)
      sec_d = (sec_q == SEC_MAX) ? '0 : sec_q + 6'd1;

    if (press_min || carry_min)
      min_d = (min_q == MIN_MAX) ? '0 : min_q + 6'd1;

    if (press_hr || carry_hr)
      hour_d = (hour_q == HR24_MAX) ? '0 : hour_q + 5'd1;

    if (press_tmod)
      mode_d = (mode_q == MODE_24H) ? MODE_12H : MODE_24H;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q  <= '0;
      sec_q  <= '0;
      min_q  <= '0;
      hour_q <= '0;
      mode_q <= MODE_24H;
    end else begin
      cnt_q  <= cnt_d;
      sec_q  <= sec_d;
      min_q  <= min_d;
      hour_q <= hour_d;
      mode_q <= mode_d;
    end
  end

  assign sec = sec_q;
  assign min = min_q;
  assign hr  = hr_display(hour_q, mode_q);

endmodule

// File: tb/tb_clock.sv
// Self-checking bench for clock: vector table, directed corner sequences and random presses vs a seconds-of-day model.
module tb_clock;

  localparam int unsigned TPS = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       set_TMOD = 1'b0;
  logic       set_min = 1'b0;
  logic       set_hr = 1'b0;
  logic [5:0] sec;
  logic [5:0] min;
  logic [4:0] hr;

  clock #(.TICKS_PER_SEC(TPS)) dut (
    .clk(clk), .rst(rst), .set_TMOD(set_TMOD), .set_min(set_min), .set_hr(set_hr),
    .sec(sec), .min(min), .hr(hr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  // Reference model: time of day as a single count of seconds since midnight.
  int m_t, m_cnt;
  bit m_12h;
  bit m_prev_t, m_prev_m, m_prev_h;

  function automatic int m_disp();
    int h;
    h = m_t / 3600;
    if (!m_12h) return h;
    if (h == 0) return 12;
    if (h > 12) return h - 12;
    return h;
  endfunction

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_t = 0; m_cnt = 0; m_12h = 0;
    m_prev_t = 0; m_prev_m = 0; m_prev_h = 0;
  endtask

  task automatic model_step(input bit tm, input bit mi, input bit hi);
    bit pt, pm, ph, tick;
    int h, m, nt, nh, nm, ns;
    pt = tm && !m_prev_t; pm = mi && !m_prev_m; ph = hi && !m_prev_h;
    m_prev_t = tm; m_prev_m = mi; m_prev_h = hi;
    tick  = (m_cnt == TPS - 1);
    m_cnt = tick ? 0 : m_cnt + 1;
    h = m_t / 3600;
    m = (m_t / 60) % 60;
    nt = tick ? (m_t + 1) % 86400 : m_t;
    nh = nt / 3600; nm = (nt / 60) % 60; ns = nt % 60;
    if (pm) begin nm = (m + 1) % 60; nh = h; end
    if (ph) nh = (h + 1) % 24;
    m_t = nh * 3600 + nm * 60 + ns;
    if (pt) m_12h = !m_12h;
  endtask

  task automatic step(input bit tm, input bit mi, input bit hi);
    set_TMOD = tm; set_min = mi; set_hr = hi;
    @(posedge clk); #1;
    model_step(tm, mi, hi);
    check("model_sec", int'(sec), m_t % 60);
    check("model_min", int'(min), (m_t / 60) % 60);
    check("model_hr",  int'(hr),  m_disp());
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    set_TMOD = 1; set_min = 1; set_hr = 1;
    #1;
    check("rst_async_sec", int'(sec), 0);
    check("rst_async_min", int'(min), 0);
    check("rst_async_hr",  int'(hr),  0);
    @(posedge clk); #1;
    set_TMOD = 0; set_min = 0; set_hr = 0;
    @(posedge clk); #1;
    set_TMOD = 1; set_min = 1; set_hr = 1;
    @(posedge clk); #1;
    check("rst_hold_sec", int'(sec), 0);
    check("rst_hold_min", int'(min), 0);
    check("rst_hold_hr",  int'(hr),  0);
    set_TMOD = 0; set_min = 0; set_hr = 0;
    rst = 1'b1;
    model_reset();
  endtask

  typedef struct {
    bit tm, mi, hi;
    int s, m, h;
  } vec_t;

  vec_t vecs[12];

  initial begin
    vecs[0]  = '{0, 1, 0, 0, 1, 0};
    vecs[1]  = '{0, 0, 0, 0, 1, 0};
    vecs[2]  = '{0, 1, 0, 0, 2, 0};
    vecs[3]  = '{0, 0, 0, 1, 2, 0};
    vecs[4]  = '{0, 0, 1, 1, 2, 1};
    vecs[5]  = '{0, 0, 0, 1, 2, 1};
    vecs[6]  = '{0, 1, 0, 1, 3, 1};
    vecs[7]  = '{0, 1, 0, 2, 3, 1};
    vecs[8]  = '{0, 1, 0, 2, 3, 1};
    vecs[9]  = '{0, 1, 0, 2, 3, 1};
    vecs[10] = '{0, 1, 0, 2, 3, 1};
    vecs[11] = '{0, 0, 0, 3, 3, 1};

    model_reset();
    do_reset();

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].tm, vecs[i].mi, vecs[i].hi);
      check($sformatf("vec%0d_sec", i), int'(sec), vecs[i].s);
      check($sformatf("vec%0d_min", i), int'(min), vecs[i].m);
      check($sformatf("vec%0d_hr", i),  int'(hr),  vecs[i].h);
    end

    // Free run across a minute boundary from 00:00:58.
    do_reset();
    idle(232);
    check("fr58_sec", int'(sec), 58);
    check("fr58_min", int'(min), 0);
    idle(8);
    check("fr_sec", int'(sec), 0);
    check("fr_min", int'(min), 1);

    // Set 23:59:59 then roll over to midnight.
    do_reset();
    for (int i = 0; i < 23; i++) begin step(0, 0, 1); step(0, 0, 0); end
    for (int i = 0; i < 59; i++) begin step(0, 1, 0); step(0, 0, 0); end
    idle(72);
    check("eod_sec", int'(sec), 59);
    check("eod_min", int'(min), 59);
    check("eod_hr",  int'(hr),  23);
    idle(4);
    check("mid_sec", int'(sec), 0);
    check("mid_min", int'(min), 0);
    check("mid_hr",  int'(hr),  0);

    // 12h display of midnight and 13:xx, then back to 24h.
    step(1, 0, 0);
    check("m12_midnight", int'(hr), 12);
    step(0, 0, 0);
    for (int i = 0; i < 13; i++) begin step(0, 0, 1); step(0, 0, 0); end
    check("m12_13h", int'(hr), 1);
    step(1, 0, 0);
    check("m24_13h", int'(hr), 13);
    step(0, 0, 0);

    // Minute press on the exact tick that would carry into minutes.
    do_reset();
    idle(239);
    check("pri_pre_sec", int'(sec), 59);
    step(0, 1, 0);
    check("pri_min", int'(min), 1);
    check("pri_sec", int'(sec), 0);
    check("pri_hr",  int'(hr),  0);
    step(0, 0, 0);

    // Random button activity against the model, including mid-run reset.
    do_reset();
    for (int i = 0; i < 1500; i++)
      step($urandom_range(0, 7) == 0, $urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0);
    do_reset();
    for (int i = 0; i < 300; i++)
      step($urandom_range(0, 5) == 0, $urandom_range(0, 1) == 0, $urandom_range(0, 1) == 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
